// File: rtl/harness_pkg.sv
// Purpose: shared types and constants for the benchmarking-harness stream sink.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package harness_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } harness_state_e;

  localparam int LFSR_W = 16;

  // Right-shifting Fibonacci form: feedback from bits 0,2,3,5 realises taps 16,14,13,11.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

  localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/harness_lfsr.sv
// Purpose: 16-bit Fibonacci LFSR driving pseudo-random stall decisions.
// Latency: new state one cycle after load/enable; reset and load take the seed.
// Backpressure: none; free-running while enable is high.
module harness_lfsr
  import harness_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              enable,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] state
);

  logic feedback;

  assign feedback = ^(state & LFSR_TAPS);

  // Reload on reset or load, otherwise shift right one step per enabled cycle.
  always_ff @(posedge clk) begin
    if (!rst_n || load) begin
      state <= seed;
    end else if (enable) begin
      state <= {feedback, state[LFSR_W-1:1]};
    end
  end

endmodule

// File: rtl/harness_sink.sv
// Purpose: AXI-Stream sink folding beat parity into a checksum, counting beats/cycles (stalls under HARNESS_SINK_STALL_EN).
// Latency: tready the cycle after start; checksum/beat_count/done update one cycle after each handshake.
// Backpressure: tready from registered state only; pseudo-random ~75% duty when HARNESS_SINK_STALL_EN is defined.
module harness_sink
  import harness_pkg::*;
#(
  parameter int                WIDTH     = 8,
  parameter int                CNT_WIDTH = 32,
  parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_DEFAULT_SEED
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic [WIDTH-1:0]     s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] expected_beats,
  output logic                 done,
  output logic                 checksum,
  output logic [CNT_WIDTH-1:0] beat_count,
  output logic [CNT_WIDTH-1:0] cycle_count
);

  // An all-zero seed would lock the stall LFSR; reject it at elaboration.
  if (LFSR_SEED == '0) begin : g_seed_chk
    $error("harness_sink: LFSR_SEED must be nonzero");
  end

  harness_state_e       state;
  logic [CNT_WIDTH-1:0] target;
  logic                 handshake;
  logic                 beat_parity;

  assign handshake   = s_axis_tvalid & s_axis_tready;
  assign beat_parity = ^s_axis_tdata;

`ifdef HARNESS_SINK_STALL_EN
  logic [LFSR_W-1:0] lfsr_q;

  harness_lfsr u_lfsr (
    .clk    (ap_clk),
    .rst_n  (ap_rst_n),
    .load   (start && (state != ST_RUN)),
    .enable (state == ST_RUN),
    .seed   (LFSR_SEED),
    .state  (lfsr_q)
  );

  assign s_axis_tready = (state == ST_RUN) && (lfsr_q[1:0] != 2'b00);
`else
  assign s_axis_tready = (state == ST_RUN);
`endif

  // Run-control FSM with the checksum and both counters as registered outputs.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state       <= ST_IDLE;
      done        <= 1'b0;
      checksum    <= 1'b0;
      beat_count  <= '0;
      cycle_count <= '0;
      target      <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            target      <= expected_beats;
            checksum    <= 1'b0;
            beat_count  <= '0;
            cycle_count <= '0;
            if (expected_beats == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_RUN;
              done  <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          cycle_count <= cycle_count + CNT_WIDTH'(1);
          if (handshake) begin
            checksum   <= checksum ^ beat_parity;
            beat_count <= beat_count + CNT_WIDTH'(1);
            if (beat_count == target - CNT_WIDTH'(1)) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/harness_sink.md
# harness_sink

AXI-Stream sink terminating the output stream of a design under test in the benchmarking harness. Accepts a programmed number of beats and folds each accepted beat into a running parity checksum (XOR-reduction of the beat, XORed into one bit), so synthesis cannot prune the DUT datapath. Counts accepted beats and active cycles for throughput measurement. Optionally applies pseudo-random backpressure.

## Interface
Parameters:
- WIDTH, 8, data width of s_axis_tdata in bits (≥1)
- CNT_WIDTH, 32, width of beat and cycle counters
- LFSR_SEED, 16'hACE1, nonzero seed for the stall LFSR (used only with stall enabled)

Ports:
- ap_clk  input  1  clock; all logic on rising edge
- ap_rst_n  input  1  reset, synchronous, active-low
- s_axis_tdata  input  WIDTH  stream data from DUT
- s_axis_tvalid  input  1  stream valid
- s_axis_tready  output  1  stream ready
- start  input  1  single-cycle pulse; arms a new run
- expected_beats  input  CNT_WIDTH  beats to accept in a run; sampled when start is accepted
- done  output  1  run complete; held until next accepted start
- checksum  output  1  XOR of all bits of all beats accepted this run
- beat_count  output  CNT_WIDTH  beats accepted this run
- cycle_count  output  CNT_WIDTH  cycles spent in RUN this run

## Operation
- States: IDLE, RUN, DONE.
- Reset (ap_rst_n=0 at an edge): state=IDLE; s_axis_tready=0, done=0, checksum=0, beat_count=0, cycle_count=0; internal target=0; LFSR=LFSR_SEED.
- IDLE/DONE + start=1: target<=expected_beats, checksum<=0, beat_count<=0, cycle_count<=0, LFSR<=LFSR_SEED, done<=0; next state RUN if expected_beats≠0, else DONE (done=1 next cycle, counters 0).
- start in RUN: ignored.
- RUN: cycle_count increments every cycle. Handshake = s_axis_tvalid & s_axis_tready. On handshake: checksum <= checksum ^ (^s_axis_tdata); beat_count += 1. If handshake and beat_count == target-1: next state DONE, done<=1.
- DONE: s_axis_tready=0; all outputs hold.
- s_axis_tready is a function of registered state only (no combinational path from tvalid or start).
- Counters wrap modulo 2^CNT_WIDTH; no saturation.
- tdata ignored when no handshake.

## Timing
- s_axis_tready rises the cycle after start is accepted (first RUN cycle).
- Last handshake in cycle N: done=1, tready=0, final checksum/beat_count visible in cycle N+1.
- cycle_count includes the first RUN cycle and the last-handshake cycle; with no stalls and tvalid held high, cycle_count == beat_count == target.
- Checksum latency: one cycle after each handshake.
- Reset mid-run: reset values at the next edge, in-flight beat discarded, run abandoned.

## Configuration
- HARNESS_SINK_STALL_EN defined: 16-bit Fibonacci LFSR (taps 16,14,13,11), reseeded on accepted start and advancing every RUN cycle. In RUN, s_axis_tready = (lfsr[1:0] != 2'b00), about 75 % duty.
- HARNESS_SINK_STALL_EN undefined: LFSR not instantiated. s_axis_tready = (state == RUN).

## Structure
- Shared package harness_pkg: state enum type, LFSR width and tap-mask constant, default seed constant.
- One sub-module, harness_lfsr (load, enable, seed in, state out), instantiated only under HARNESS_SINK_STALL_EN.
- Parity reduction, FSM and counters live in harness_sink.

## Test plan
- Reset, then idle 5 cycles with tvalid=1 -> tready=0, done=0, all counters 0.
- Stall disabled, WIDTH=8, expected_beats=4, tvalid held high, data 0x01,0x03,0x07,0x00 -> checksum=0, beat_count=4, cycle_count=4, done the cycle after the 4th beat, tready=0 from then on.
- Same run with data 0x01,0x02,0x04,0x80 -> checksum=0; with data 0x01,0x00,0x00,0x00 -> checksum=1.
- expected_beats=0 + start -> done=1 the next cycle, tready never asserts, counters 0.
- tvalid toggled 1,0,1,0,… with expected_beats=3 and stall disabled -> beat_count=3, cycle_count=5; start pulsed during RUN has no effect.
- Stall enabled, seed 16'hACE1, expected_beats=100 -> tready pattern matches the reference LFSR model, beat_count=100, cycle_count>100. Reset asserted at beat 50 -> next cycle all outputs 0, state IDLE.
